// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter: state encoding and frame length.
package serial_frame_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Clocks from the first START cycle through the last STOP cycle.
    function automatic int unsigned frame_len(input int unsigned data_w,
                                              input int unsigned parity_en,
                                              input int unsigned bit_cycles);
        return (2 + data_w + parity_en) * bit_cycles;
    endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Valid/ready word handshake between the upstream producer and the frame transmitter.
interface serial_frame_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/serial_bit_timer.sv
// Free-running bit-period counter; bit_tick marks the last clock of each serial bit.
module serial_bit_timer #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);
    localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign bit_tick = (r_cnt == CNT_W'(BIT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (restart || bit_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data, optional parity, stop bit.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    serial_frame_tx_if.slave  tx,
    output logic              sdout,
    output logic              busy,
    output logic              frame_done
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    state_t            r_state, w_state_n;
    logic [DATA_W-1:0] r_shift, w_shift_n;
    logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_n;
    logic              r_parity, w_parity_n;
    logic              r_sdout, w_sdout_n;
    logic              r_ready, w_ready_n;
    logic              r_busy, w_busy_n;
    logic              r_done, w_done_n;
    logic              w_accept;
    logic              w_bit_tick;

    assign w_accept    = (r_state == ST_IDLE) && tx.tx_valid && r_ready;
    assign tx.tx_ready = r_ready;
    assign sdout       = r_sdout;
    assign busy        = r_busy;
    assign frame_done  = r_done;

    serial_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (w_accept),
        .bit_tick (w_bit_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_sdout   <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_shift   <= w_shift_n;
            r_bit_cnt <= w_bit_cnt_n;
            r_parity  <= w_parity_n;
            r_sdout   <= w_sdout_n;
            r_ready   <= w_ready_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
        end
    end

    // Outputs are computed from the next state so their registers line up with r_state.
    always_comb begin
        w_state_n   = r_state;
        w_shift_n   = r_shift;
        w_bit_cnt_n = r_bit_cnt;
        w_parity_n  = r_parity;
        w_done_n    = 1'b0;
        w_sdout_n   = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_n  = ST_START;
                    w_shift_n  = tx.tx_data;
                    w_parity_n = (^tx.tx_data) ^ 1'(PARITY_ODD);
                end
            end
            ST_START: begin
                if (w_bit_tick) begin
                    w_state_n   = ST_DATA;
                    w_bit_cnt_n = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_tick) begin
                    w_shift_n = r_shift >> 1;
                    if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                        w_bit_cnt_n = '0;
                        w_state_n   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_cnt_n = r_bit_cnt + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_tick) begin
                    w_state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_tick) begin
                    w_state_n = ST_IDLE;
                    w_done_n  = 1'b1;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        case (w_state_n)
            ST_START:  w_sdout_n = 1'b0;
            ST_DATA:   w_sdout_n = w_shift_n[0];
            ST_PARITY: w_sdout_n = w_parity_n;
            default:   w_sdout_n = 1'b1;
        endcase

        w_ready_n = (w_state_n == ST_IDLE);
        w_busy_n  = (w_state_n != ST_IDLE);
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench: four transmitter configurations plus a downstream SISO stage on the default one.
module tb_serial_frame_tx;
    import serial_frame_pkg::*;

    localparam int unsigned NDUT  = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BC [NDUT] = '{1, 1, 1, 4};
    localparam int unsigned PE [NDUT] = '{1, 1, 0, 1};
    localparam int unsigned PO [NDUT] = '{0, 1, 0, 0};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       tv [NDUT];
    logic [7:0] td [NDUT];
    logic       sd [NDUT];
    logic       bz [NDUT];
    logic       rd [NDUT];
    logic       dn [NDUT];

    serial_frame_tx_if #(.DATA_W(8)) if0 ();
    serial_frame_tx_if #(.DATA_W(8)) if1 ();
    serial_frame_tx_if #(.DATA_W(8)) if2 ();
    serial_frame_tx_if #(.DATA_W(8)) if3 ();

    assign if0.tx_valid = tv[0]; assign if0.tx_data = td[0]; assign rd[0] = if0.tx_ready;
    assign if1.tx_valid = tv[1]; assign if1.tx_data = td[1]; assign rd[1] = if1.tx_ready;
    assign if2.tx_valid = tv[2]; assign if2.tx_data = td[2]; assign rd[2] = if2.tx_ready;
    assign if3.tx_valid = tv[3]; assign if3.tx_data = td[3]; assign rd[3] = if3.tx_ready;

    serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(1), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .rst(rst_n), .tx(if0.slave), .sdout(sd[0]), .busy(bz[0]), .frame_done(dn[0]));
    serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(1), .PARITY_ODD(1)) u_dut1 (
        .clk(clk), .rst(rst_n), .tx(if1.slave), .sdout(sd[1]), .busy(bz[1]), .frame_done(dn[1]));
    serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(0), .PARITY_ODD(0)) u_dut2 (
        .clk(clk), .rst(rst_n), .tx(if2.slave), .sdout(sd[2]), .busy(bz[2]), .frame_done(dn[2]));
    serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4), .PARITY_EN(1), .PARITY_ODD(0)) u_dut3 (
        .clk(clk), .rst(rst_n), .tx(if3.slave), .sdout(sd[3]), .busy(bz[3]), .frame_done(dn[3]));

    // Downstream SISO shift register fed by the default transmitter.
    logic [DEPTH-1:0] r_siso;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_siso <= '1;
        else        r_siso <= {r_siso[DEPTH-2:0], sd[0]};
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each entry is the expected {sdout, busy, tx_ready, frame_done} for one clock.
    logic [3:0]  exp_q [$];
    logic        mon_en = 1'b0;
    int unsigned sel = 0;
    int unsigned bz_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned exp_done = 0;
    logic [DEPTH-1:0] exp_hist = '1;

    task automatic push_frame(input int unsigned idx, input logic [7:0] w);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(w[i]);
        if (PE[idx] != 0) bits.push_back((^w) ^ 1'(PO[idx]));
        bits.push_back(1'b1);
        foreach (bits[i])
            for (int c = 0; c < int'(BC[idx]); c++) exp_q.push_back({bits[i], 3'b100});
        exp_q.push_back(4'b1011);
        exp_done++;
    endtask

    logic [3:0] m_got, m_exp;
    logic       m_sd0;
    always @(negedge clk) begin
        if (mon_en) begin
            m_got = {sd[sel], bz[sel], rd[sel], dn[sel]};
            m_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b1010;
            chk($sformatf("cycle dut%0d {sd,busy,rdy,done}", sel), 32'(m_got), 32'(m_exp));
            if (bz[sel]) bz_cnt++;
            if (dn[sel]) begin
                chk($sformatf("frame_len dut%0d", sel), bz_cnt, frame_len(8, PE[sel], BC[sel]));
                bz_cnt = 0;
                done_cnt++;
            end
            m_sd0 = (sel == 0) ? m_exp[3] : 1'b1;
            chk("siso dout", 32'(r_siso[DEPTH-1]), 32'(exp_hist[DEPTH-1]));
            exp_hist = {exp_hist[DEPTH-2:0], m_sd0};
        end
    end

    task automatic send_one(input int unsigned idx, input logic [7:0] w, input bit poke);
        sel     = idx;
        tv[idx] = 1'b1;
        td[idx] = w;
        @(posedge clk);
        push_frame(idx, w);
        #1;
        tv[idx] = 1'b0;
        td[idx] = ~w;
        if (poke) begin
            @(posedge clk); #1;
            tv[idx] = 1'b1;
            repeat (3) @(posedge clk);
            #1 tv[idx] = 1'b0;
        end
        repeat (frame_len(8, PE[idx], BC[idx]) + 6) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < int'(NDUT); i++) begin tv[i] = 1'b0; td[i] = 8'h00; end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < int'(NDUT); i++)
            chk($sformatf("reset dut%0d {sd,busy,rdy,done}", i), 32'({sd[i], bz[i], rd[i], dn[i]}), 32'(4'b1010));
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        send_one(0, 8'hA5, 1'b0);
        send_one(0, 8'h07, 1'b1);
        send_one(1, 8'h07, 1'b1);
        send_one(2, 8'h5A, 1'b0);
        send_one(3, 8'h01, 1'b0);
        sel = 0;

        // Back-to-back: valid held high, data changed mid-frame to the second word.
        tv[0] = 1'b1;
        td[0] = 8'h01;
        @(posedge clk);
        push_frame(0, 8'h01);
        #1 td[0] = 8'h80;
        repeat (frame_len(8, 1, 1) + 1) @(posedge clk);
        push_frame(0, 8'h80);
        #1 tv[0] = 1'b0;
        repeat (frame_len(8, 1, 1) + 6) @(posedge clk);
        #1;

        // Reset asserted during data bit 3 of 0xFF.
        tv[0] = 1'b1;
        td[0] = 8'hFF;
        @(posedge clk);
        push_frame(0, 8'hFF);
        #1 tv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async reset sdout", 32'(sd[0]), 32'd1);
        chk("async reset busy", 32'(bz[0]), 32'd0);
        chk("async reset ready", 32'(rd[0]), 32'd1);
        exp_q.delete();
        exp_done--;
        bz_cnt   = 0;
        exp_hist = '1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post-reset ready", 32'(rd[0]), 32'd1);
        mon_en = 1'b1;
        send_one(0, 8'h3C, 1'b0);

        mon_en = 1'b0;
        chk("frame_done count", done_cnt, exp_done);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Parallel-to-serial frame transmitter that drives the single-bit serial input of the downstream SISO shift-register stage. It accepts a DATA_W-bit word over a valid/ready handshake and emits one frame on sdout: a start bit, the data LSB-first, an optional parity bit and a stop bit. Each bit is held for BIT_CYCLES clocks. sdout idles high.

Parameters:
DATA_W, 8, payload width in bits (≥1)
BIT_CYCLES, 1, clocks per serial bit (≥1)
PARITY_EN, 1, 1 = parity bit inserted after data; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (low = reset asserted)
tx_data  in  DATA_W  word to transmit; sampled only on handshake
tx_valid  in  1  upstream has a word
tx_ready  out  1  block can accept a word (high only in IDLE)
sdout  out  1  serial output to the downstream shift-register din
busy  out  1  frame in progress (state != IDLE)
frame_done  out  1  one-cycle pulse after the stop bit completes

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, sdout=1, tx_ready=1, busy=0, frame_done=0, shift/parity/bit counters cleared. A frame in flight is discarded. sdout goes to 1 without waiting for a clock edge.
- Handshake: the word is accepted on a rising edge where tx_valid && tx_ready. tx_data is captured into an internal shift register at that edge. Later changes to tx_data have no effect. While tx_ready=0, tx_valid is ignored and nothing is queued.
- FSM states and transitions:
  - IDLE -> START on accept.
  - START -> DATA after BIT_CYCLES clocks.
  - DATA -> PARITY (PARITY_EN=1) or STOP after DATA_W bits.
  - PARITY -> STOP.
  - STOP -> IDLE after BIT_CYCLES clocks.
- sdout per state:
  - IDLE: 1.
  - START: 0.
  - DATA: the current LSB of the shift register; it shifts right once per completed bit period.
  - PARITY: XOR of the captured word for even parity, its inverse for odd parity.
  - STOP: 1.
- Latency: the accept edge is followed by the first START cycle, which is the first clock after acceptance.
- Frame length: F = (2 + DATA_W + PARITY_EN) * BIT_CYCLES clocks.
- tx_ready, busy and frame_done are registered. frame_done=1 in the first IDLE cycle after STOP, for one cycle only.
- Back-to-back frames: with tx_valid held high, the next word is accepted at the end of that first IDLE cycle. sdout is therefore high for BIT_CYCLES+1 clocks between frames (minimum inter-frame gap = 1 idle clock).
- Bit timer: counts 0..BIT_CYCLES-1 and emits bit_tick on the terminal count. It restarts at 0 on accept. With BIT_CYCLES=1, bit_tick is high every cycle.
- Data bit counter width: $clog2(DATA_W+1). It wraps to 0 on the DATA exit.
- Reset released mid-frame: the block restarts in IDLE with tx_ready=1. No partial frame resumes.

Decomposition:
- Shared package serial_frame_pkg: state encoding localparams (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, 3 bits) and a frame-length function of DATA_W/PARITY_EN/BIT_CYCLES. The bench uses the same function.
- One sub-module, serial_bit_timer: parameter BIT_CYCLES; ports clk, rst, restart, bit_tick. The FSM, shifter and parity logic stay in serial_frame_tx.

Test Plan:
- Basic frame: defaults, send 0xA5. sdout must be 0,1,0,1,0,0,1,0,1,0,1 on consecutive cycles (start, LSB-first data, even parity 0, stop). frame_done pulses on cycle 12 after accept. tx_ready=0 for cycles 1–11.
- Parity: PARITY_ODD=0, send 0x07 -> parity bit 1. PARITY_ODD=1, send 0x07 -> parity bit 0. PARITY_EN=0 -> 10-bit frame with no parity slot.
- Bit stretching: BIT_CYCLES=4, send 0x01. Each level is held exactly 4 clocks, F=44. The start-bit low lasts exactly 4 clocks.
- Back-to-back: tx_valid held high, words 0x01 then 0x80. The second start bit begins exactly 2 clocks after the first stop bit's last clock. Both frames are bit-exact and frame_done pulses twice.
- Reset mid-frame: drive rst low during data bit 3 of 0xFF. sdout=1 and busy=0 immediately (before the next edge). After release, tx_ready=1, and a subsequent 0x3C frame is bit-exact.
- Integration: sdout is wired to the downstream SISO shift register din. Its dout reproduces the frame sequence delayed by the register depth, and it idles high after the stop bit.
